// File: rtl/gray_rx_decoder.sv
// Gray-to-binary receive decoder with single-step check and err_cnt; `GRAY_DIR_EN adds per-entry up-count flag.
// Latency: one cycle, pushed entry is visible at the FIFO head next cycle; no combinational in->out path.
// Backpressure: in_ready drops while the output FIFO is full; out_ready pops the head entry.
module gray_rx_decoder #(
  parameter int W     = 4,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    in_gray,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    out_bin,
  output logic            out_err,
  output logic            out_dir,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            err_clr,
  output logic [CNTW-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     PTR_ONE = (AW+1)'(1);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [W-1:0]    BIN_ONE = W'(1);

  typedef struct packed {
    logic [W-1:0] bin;
    logic         err;
    logic         dir;
  } entry_t;

  typedef enum logic {FIRST, TRACK} state_t;

  state_t       state, state_nxt;
  logic         track;
  logic [W-1:0] prev_gray;
  logic [W-1:0] bin;
  logic [W-1:0] step;
  logic         one_bit;
  logic         err;
  logic         dir;
  logic         push, pop;
  entry_t       mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, empty;
  entry_t       head;

  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) bin[i] = ^(in_gray >> i);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FIRST;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (push) state_nxt = TRACK;
  end

  always_comb begin
    track = (state == TRACK);
  end

  // Exactly one differing bit: non-zero and a power of two.
  assign step    = in_gray ^ prev_gray;
  assign one_bit = (step != '0) && ((step & (step - BIN_ONE)) == '0);
  assign err     = track && !one_bit;

`ifdef GRAY_DIR_EN
  logic [W-1:0] prev_bin;
  always_ff @(posedge clk) begin
    if (rst)       prev_bin <= '0;
    else if (push) prev_bin <= bin;
  end
  assign dir = track && (bin == prev_bin + BIN_ONE);
`else
  assign dir = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)       prev_gray <= '0;
    else if (push) prev_gray <= in_gray;
  end

  // A clear that coincides with an erroring push leaves that push counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= (push && err) ? CNT_ONE : '0;
    end else if (push && err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full && !rst;
  assign out_valid = !empty && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{bin: bin, err: err, dir: dir};
  end

  assign head    = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign out_bin = head.bin;
  assign out_err = head.err;
  assign out_dir = head.dir;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Scoreboard bench for gray_rx_decoder (W=4, DEPTH=2); a CNTW=2 twin shares inputs for saturation.
module tb_gray_rx_decoder;

`ifdef GRAY_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] bin;
    logic       err;
    logic       dir;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_gray = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       in_ready, out_err, out_dir, out_valid;
  logic [3:0] out_bin;
  logic [7:0] err_cnt;
  logic       in_ready2, out_err2, out_dir2, out_valid2;
  logic [3:0] out_bin2;
  logic [1:0] err_cnt2;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb [$];
  int   sat_exp [5] = '{1, 2, 3, 3, 3};

  always #5 clk = ~clk;

  gray_rx_decoder #(.W(4), .DEPTH(2), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .in_gray(in_gray), .in_valid(in_valid), .in_ready(in_ready),
    .out_bin(out_bin), .out_err(out_err), .out_dir(out_dir), .out_valid(out_valid),
    .out_ready(out_ready), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  gray_rx_decoder #(.W(4), .DEPTH(2), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .in_gray(in_gray), .in_valid(in_valid), .in_ready(in_ready2),
    .out_bin(out_bin2), .out_err(out_err2), .out_dir(out_dir2), .out_valid(out_valid2),
    .out_ready(1'b1), .err_clr(err_clr), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Head entries leaving the DUT are matched against the scoreboard in push order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pop", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_bin", 32'(out_bin), 32'(e.bin));
        chk("sb_err", 32'(out_err), 32'(e.err));
        chk("sb_dir", 32'(out_dir), 32'(e.dir));
      end
    end
  end

  task automatic push_code(input logic [3:0] g, input logic [3:0] eb, input logic ee, input logic ed);
    int   n;
    exp_t e;
    in_gray  = g;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("push_timeout", 32'd0, 32'd1);
    end else begin
      e.bin = eb;
      e.err = ee;
      e.dir = ed & DIR_EN;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bin", 32'(out_bin), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Plain in-order stream.
    out_ready = 1'b1;
    push_code(4'b0000, 4'd0, 1'b0, 1'b0);
    push_code(4'b0001, 4'd1, 1'b0, 1'b1);
    push_code(4'b0011, 4'd2, 1'b0, 1'b1);
    push_code(4'b0010, 4'd3, 1'b0, 1'b1);
    drain();
    chk("stream_err_cnt", 32'(err_cnt), 32'd0);
    chk("empty_out_valid", 32'(out_valid), 32'd0);
    chk("empty_out_bin", 32'(out_bin), 32'd0);
    chk("empty_out_err", 32'(out_err), 32'd0);
    chk("empty_out_dir", 32'(out_dir), 32'd0);

    // Wrap-around step is legal.
    do_reset();
    out_ready = 1'b1;
    push_code(4'b1001, 4'd14, 1'b0, 1'b0);
    push_code(4'b1000, 4'd15, 1'b0, 1'b1);
    push_code(4'b0000, 4'd0,  1'b0, 1'b1);
    drain();
    chk("wrap_err_cnt", 32'(err_cnt), 32'd0);

    // Two-bit jump and a repeated code are both violations.
    do_reset();
    out_ready = 1'b1;
    push_code(4'b0000, 4'd0, 1'b0, 1'b0);
    push_code(4'b0011, 4'd2, 1'b1, 1'b0);
    push_code(4'b0011, 4'd2, 1'b1, 1'b0);
    chk("viol_err_cnt", 32'(err_cnt), 32'd2);
    drain();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);

    // Backpressure: full FIFO holds off a third code.
    do_reset();
    out_ready = 1'b0;
    push_code(4'b0001, 4'd1, 1'b0, 1'b0);
    push_code(4'b0011, 4'd2, 1'b0, 1'b1);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    in_gray  = 4'b0010;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_head_stable", 32'(out_bin), 32'd1);
    end
    out_ready = 1'b1;
    push_code(4'b0010, 4'd3, 1'b0, 1'b1);
    drain();
    chk("bp_err_cnt", 32'(err_cnt), 32'd0);

    // Reset mid-stream discards entries; next push is unchecked.
    do_reset();
    out_ready = 1'b0;
    push_code(4'b0001, 4'd1, 1'b0, 1'b0);
    push_code(4'b0011, 4'd2, 1'b0, 1'b1);
    chk("mid_full", 32'(in_ready), 32'd0);
    do_reset();
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_err_cnt", 32'(err_cnt), 32'd0);
    out_ready = 1'b1;
    push_code(4'b0110, 4'd4, 1'b0, 1'b0);
    drain();
    chk("mid_first_err_cnt", 32'(err_cnt), 32'd0);

    // Saturation on the CNTW=2 twin.
    do_reset();
    out_ready = 1'b1;
    push_code(4'b0000, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      push_code(4'b0000, 4'd0, 1'b1, 1'b0);
      chk("sat_cnt", 32'(err_cnt2), 32'(sat_exp[i]));
    end
    chk("sat_wide_cnt", 32'(err_cnt), 32'd5);
    err_clr = 1'b1;
    push_code(4'b0000, 4'd0, 1'b1, 1'b0);
    err_clr = 1'b0;
    chk("sat_clr_push_cnt", 32'(err_cnt2), 32'd1);
    chk("wide_clr_push_cnt", 32'(err_cnt), 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
